// File: rtl/car_loop_filter.sv
// Costas carrier loop back-end: sign(I)*Q discriminator, PI filter, lock detect, NCO FCW out.
// Latency: dump sampled at edge N -> tx_car_fcw / tx_fcw_valid at edge N+3; one dump per 4 clocks.
// Backpressure: none; a dump arriving while an update is in flight is discarded and flagged on tx_drop.
module car_loop_filter #(
   parameter int                   CORR_WIDTH = 24,
   parameter int                   ACC_WIDTH  = 32,
   parameter int                   ERR_WIDTH  = 12,
   parameter int                   DISC_SHIFT = 8,
   parameter int                   KP_SHIFT   = 6,
   parameter int                   KI_SHIFT   = 2,
   parameter logic [ACC_WIDTH-1:0] INT_LIM    = 32'h0010_0000,
   parameter int                   LOCK_CNT   = 16
) (
   input  logic                         rx_clk,
   input  logic                         rx_rst_n,
   input  logic                         rx_loop_en,
   input  logic [ACC_WIDTH-1:0]         rx_car_fcw_nom,
   input  logic                         rx_corr_valid,
   input  logic signed [CORR_WIDTH-1:0] rx_corr_i,
   input  logic signed [CORR_WIDTH-1:0] rx_corr_q,
   output logic [ACC_WIDTH-1:0]         tx_car_fcw,
   output logic                         tx_fcw_valid,
   output logic                         tx_lock,
   output logic                         tx_drop
);

   localparam int CNT_W = $clog2(LOCK_CNT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_CNT);
   localparam logic signed [CORR_WIDTH:0] ERR_MAX = (CORR_WIDTH+1)'((2**(ERR_WIDTH-1)) - 1);
   localparam logic signed [CORR_WIDTH:0] ERR_MIN = (CORR_WIDTH+1)'(-(2**(ERR_WIDTH-1)));
   localparam logic signed [ACC_WIDTH:0]  LIM_P   = {1'b0, INT_LIM};
   localparam logic signed [ACC_WIDTH:0]  LIM_N   = -LIM_P;

   typedef enum logic [1:0] {ST_IDLE, ST_DISC, ST_FILT, ST_UPD} state_t;

   state_t state_q, state_d;

   logic signed [CORR_WIDTH-1:0] corr_i_q, corr_q_q;
   logic signed [ERR_WIDTH-1:0]  err_q, err_d;
   logic [CORR_WIDTH-1:0]        abs_i_q, abs_q_q, abs_i_d, abs_q_d;
   logic signed [ACC_WIDTH-1:0]  intg_q, intg_d;
   logic signed [ACC_WIDTH-1:0]  prop_q, prop_d;
   logic [CNT_W-1:0]             cnt_q, cnt_d;

   logic signed [CORR_WIDTH:0]   q_ext, q_rot, q_shf;
   logic signed [ACC_WIDTH-1:0]  err_ext, ki_term;
   logic signed [ACC_WIDTH:0]    intg_sum;
   logic                         in_phase;
   logic                         capture;

   assign capture = rx_loop_en && rx_corr_valid && (state_q == ST_IDLE);

   // ---------------- control ----------------
   always_ff @(posedge rx_clk or negedge rx_rst_n) begin
      if (!rx_rst_n) state_q <= ST_IDLE;
      else           state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (!rx_loop_en) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: if (rx_corr_valid) state_d = ST_DISC;
            ST_DISC: state_d = ST_FILT;
            ST_FILT: state_d = ST_UPD;
            ST_UPD:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // ---------------- discriminator ----------------
   // One extra bit so that negating the most negative Q cannot overflow; I==0 counts as positive.
   always_comb begin
      q_ext = {corr_q_q[CORR_WIDTH-1], corr_q_q};
      q_rot = corr_i_q[CORR_WIDTH-1] ? -q_ext : q_ext;
      q_shf = q_rot >>> DISC_SHIFT;
      if (q_shf > ERR_MAX)      err_d = ERR_MAX[ERR_WIDTH-1:0];
      else if (q_shf < ERR_MIN) err_d = ERR_MIN[ERR_WIDTH-1:0];
      else                      err_d = q_shf[ERR_WIDTH-1:0];
      abs_i_d = corr_i_q[CORR_WIDTH-1] ? (~corr_i_q) + CORR_WIDTH'(1) : corr_i_q;
      abs_q_d = corr_q_q[CORR_WIDTH-1] ? (~corr_q_q) + CORR_WIDTH'(1) : corr_q_q;
   end

   // ---------------- PI filter and lock counter ----------------
   always_comb begin
      err_ext  = {{(ACC_WIDTH-ERR_WIDTH){err_q[ERR_WIDTH-1]}}, err_q};
      ki_term  = err_ext <<< KI_SHIFT;
      prop_d   = err_ext <<< KP_SHIFT;
      intg_sum = {intg_q[ACC_WIDTH-1], intg_q} + {ki_term[ACC_WIDTH-1], ki_term};
      if (intg_sum > LIM_P)      intg_d = LIM_P[ACC_WIDTH-1:0];
      else if (intg_sum < LIM_N) intg_d = LIM_N[ACC_WIDTH-1:0];
      else                       intg_d = intg_sum[ACC_WIDTH-1:0];
      in_phase = {1'b0, abs_i_q} >= {abs_q_q, 1'b0};
      if (!in_phase)             cnt_d = '0;
      else if (cnt_q == CNT_MAX) cnt_d = cnt_q;
      else                       cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge rx_clk or negedge rx_rst_n) begin
      if (!rx_rst_n) begin
         corr_i_q <= '0;
         corr_q_q <= '0;
         err_q    <= '0;
         abs_i_q  <= '0;
         abs_q_q  <= '0;
         prop_q   <= '0;
      end else begin
         if (capture) begin
            corr_i_q <= rx_corr_i;
            corr_q_q <= rx_corr_q;
         end
         if (state_q == ST_DISC) begin
            err_q   <= err_d;
            abs_i_q <= abs_i_d;
            abs_q_q <= abs_q_d;
         end
         if (state_q == ST_FILT) prop_q <= prop_d;
      end
   end

   // Loop state is discarded whenever the loop is opened so a re-close starts clean.
   always_ff @(posedge rx_clk or negedge rx_rst_n) begin
      if (!rx_rst_n) begin
         intg_q <= '0;
         cnt_q  <= '0;
      end else if (!rx_loop_en) begin
         intg_q <= '0;
         cnt_q  <= '0;
      end else if (state_q == ST_FILT) begin
         intg_q <= intg_d;
         cnt_q  <= cnt_d;
      end
   end

   // ---------------- outputs ----------------
   always_ff @(posedge rx_clk or negedge rx_rst_n) begin
      if (!rx_rst_n) begin
         tx_car_fcw   <= '0;
         tx_fcw_valid <= 1'b0;
         tx_lock      <= 1'b0;
         tx_drop      <= 1'b0;
      end else if (!rx_loop_en) begin
         tx_car_fcw   <= rx_car_fcw_nom;
         tx_fcw_valid <= 1'b0;
         tx_lock      <= 1'b0;
         tx_drop      <= 1'b0;
      end else begin
         tx_fcw_valid <= (state_q == ST_UPD);
         tx_drop      <= rx_corr_valid && (state_q != ST_IDLE);
         if (state_q == ST_UPD) begin
            // Modulo-2^ACC_WIDTH sum: the NCO word wraps by design.
            tx_car_fcw <= rx_car_fcw_nom + prop_q + intg_q;
            tx_lock    <= (cnt_q == CNT_MAX);
         end
      end
   end

endmodule

// File: tb/tb_car_loop_filter.sv
// Randomised scoreboard bench for car_loop_filter against an integer-arithmetic loop model.
module tb_car_loop_filter;

   logic               rx_clk = 1'b0;
   logic               rx_rst_n;
   logic               rx_loop_en;
   logic [31:0]        rx_car_fcw_nom;
   logic               rx_corr_valid;
   logic signed [23:0] rx_corr_i;
   logic signed [23:0] rx_corr_q;
   logic [31:0]        tx_car_fcw;
   logic               tx_fcw_valid;
   logic               tx_lock;
   logic               tx_drop;

   car_loop_filter dut (
      .rx_clk        (rx_clk),
      .rx_rst_n      (rx_rst_n),
      .rx_loop_en    (rx_loop_en),
      .rx_car_fcw_nom(rx_car_fcw_nom),
      .rx_corr_valid (rx_corr_valid),
      .rx_corr_i     (rx_corr_i),
      .rx_corr_q     (rx_corr_q),
      .tx_car_fcw    (tx_car_fcw),
      .tx_fcw_valid  (tx_fcw_valid),
      .tx_lock       (tx_lock),
      .tx_drop       (tx_drop)
   );

   always #5 rx_clk = ~rx_clk;

   typedef struct {
      logic [31:0] fcw;
      logic        lock;
      int          cyc;
   } exp_t;

   exp_t   upd_q[$];
   int     drop_q[$];
   int     cyc = 0;
   int     checks = 0;
   int     errors = 0;

   // reference model state
   longint intg_m = 0;
   int     cnt_m = 0;

   always @(posedge rx_clk) cyc = cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge rx_clk);
      #1;
   endtask

   task automatic model_reset();
      intg_m = 0;
      cnt_m  = 0;
   endtask

   // Loop behaviour written as plain integer arithmetic.
   task automatic model_dump(input logic signed [23:0] i, input logic signed [23:0] q,
                             input logic [31:0] nom, output exp_t e);
      longint li, lq, err, prop, sum, ai, aq, ln;
      li = i;
      lq = q;
      ln = nom;
      err = (li < 0) ? -lq : lq;
      err = err >>> 8;
      if (err > 2047)  err = 2047;
      if (err < -2048) err = -2048;
      intg_m = intg_m + err * 4;
      if (intg_m > 1048576)  intg_m = 1048576;
      if (intg_m < -1048576) intg_m = -1048576;
      prop = err * 64;
      sum  = ln + prop + intg_m;
      ai = (li < 0) ? -li : li;
      aq = (lq < 0) ? -lq : lq;
      if (ai >= 2 * aq) cnt_m = (cnt_m < 16) ? cnt_m + 1 : 16;
      else              cnt_m = 0;
      e.fcw  = sum[31:0];
      e.lock = (cnt_m == 16);
   endtask

   // Issue one dump and spend its 4-cycle slot; drop_at 1..3 adds a colliding strobe.
   task automatic send(input logic signed [23:0] i, input logic signed [23:0] q, input int drop_at);
      exp_t e;
      rx_corr_valid = 1'b1;
      rx_corr_i = i;
      rx_corr_q = q;
      model_dump(i, q, rx_car_fcw_nom, e);
      e.cyc = cyc + 4;
      upd_q.push_back(e);
      tick();
      rx_corr_valid = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         if (k == drop_at) begin
            rx_corr_valid = 1'b1;
            rx_corr_i = 24'($urandom);
            rx_corr_q = 24'($urandom);
            drop_q.push_back(cyc + 1);
         end
         tick();
         rx_corr_valid = 1'b0;
      end
   endtask

   task automatic fresh();
      rx_loop_en = 1'b0;
      tick();
      rx_loop_en = 1'b1;
      model_reset();
   endtask

   // Monitor: every output event must match the head of its queue.
   always @(negedge rx_clk) begin
      if (rx_rst_n) begin
         if (tx_fcw_valid) begin
            if (upd_q.size() == 0) begin
               check("unexpected_fcw_valid", 64'(tx_fcw_valid), 64'd0);
            end else begin
               exp_t e;
               e = upd_q.pop_front();
               check("fcw", 64'(tx_car_fcw), 64'(e.fcw));
               check("lock", 64'(tx_lock), 64'(e.lock));
               check("upd_latency", 64'(cyc), 64'(e.cyc));
            end
         end
         if (tx_drop) begin
            if (drop_q.size() == 0) begin
               check("unexpected_drop", 64'(tx_drop), 64'd0);
            end else begin
               int c;
               c = drop_q.pop_front();
               check("drop_cycle", 64'(cyc), 64'(c));
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic signed [23:0] ri, rq;
      rx_rst_n = 1'b0;
      rx_loop_en = 1'b0;
      rx_car_fcw_nom = 32'h1234_5678;
      rx_corr_valid = 1'b0;
      rx_corr_i = '0;
      rx_corr_q = '0;
      #12;
      check("rst_fcw", 64'(tx_car_fcw), 64'd0);
      check("rst_valid", 64'(tx_fcw_valid), 64'd0);
      check("rst_lock", 64'(tx_lock), 64'd0);
      check("rst_drop", 64'(tx_drop), 64'd0);
      tick();
      rx_rst_n = 1'b1;

      // T1: open loop follows nominal, strobes ignored
      for (int n = 0; n < 4; n++) begin
         rx_corr_valid = 1'b1;
         rx_corr_i = 24'sd1000;
         rx_corr_q = 24'sd25600;
         tick();
         rx_corr_valid = 1'b0;
         check("open_fcw", 64'(tx_car_fcw), 64'h1234_5678);
         repeat (9) tick();
      end
      rx_car_fcw_nom = 32'h0BAD_F00D;
      tick();
      check("open_track", 64'(tx_car_fcw), 64'h0BAD_F00D);

      // T2 / T3 / T4 directed
      rx_car_fcw_nom = 32'h1000_0000;
      fresh();
      send(24'sd1000, 24'sd25600, 0);
      check("t2_fcw", 64'(tx_car_fcw), 64'h1000_1A90);
      tick();
      check("idle_hold", 64'(tx_car_fcw), 64'h1000_1A90);
      fresh();
      send(-24'sd1000, 24'sd25600, 0);
      check("t3_neg_fcw", 64'(tx_car_fcw), 64'h0FFF_E570);
      fresh();
      send(24'sd1000, 24'sh7F_FFFF, 0);
      check("t3_sat_pos", 64'(tx_car_fcw), 64'(32'h1000_0000 + 32'd131008 + 32'd8188));
      fresh();
      send(24'sd1000, 24'sh80_0000, 0);
      check("t3_sat_neg", 64'(tx_car_fcw), 64'(32'h1000_0000 - 32'd131072 - 32'd8192));
      rx_car_fcw_nom = 32'hFFFF_FFF0;
      fresh();
      send(24'sd1000, 24'sd25600, 0);
      check("t4_wrap", 64'(tx_car_fcw), 64'h0000_1A80);

      // T5: integrator clamp
      rx_car_fcw_nom = 32'h2000_0000;
      fresh();
      for (int n = 0; n < 135; n++) send(24'sd1000, 24'sh7F_FFFF, 0);
      check("t5_clamp", 64'(tx_car_fcw), 64'(32'h2000_0000 + 32'd131008 + 32'h0010_0000));

      // T6: lock acquisition and loss
      fresh();
      for (int n = 0; n < 15; n++) send(24'sd20000, 24'sd100, 0);
      check("t6_not_yet", 64'(tx_lock), 64'd0);
      send(24'sd20000, 24'sd100, 0);
      check("t6_lock", 64'(tx_lock), 64'd1);
      send(24'sd20000, 24'sd15000, 0);
      check("t6_unlock", 64'(tx_lock), 64'd0);

      // T7: collisions and reset mid-update
      fresh();
      send(24'sd1000, 24'sd25600, 1);
      send(-24'sd3000, 24'sd5000, 2);
      send(24'sd7, -24'sd90000, 3);
      rx_corr_valid = 1'b1;
      rx_corr_i = 24'sd1000;
      rx_corr_q = 24'sd25600;
      tick();
      rx_corr_valid = 1'b0;
      tick();
      rx_rst_n = 1'b0;
      #1;
      check("rst_filt_fcw", 64'(tx_car_fcw), 64'd0);
      check("rst_filt_valid", 64'(tx_fcw_valid), 64'd0);
      check("rst_filt_lock", 64'(tx_lock), 64'd0);
      check("rst_filt_drop", 64'(tx_drop), 64'd0);
      model_reset();
      tick();
      tick();
      rx_rst_n = 1'b1;
      repeat (4) tick();

      // Randomised mix
      for (int n = 0; n < 250; n++) begin
         int mode;
         if ($urandom_range(0, 19) == 0) rx_car_fcw_nom = $urandom;
         if ($urandom_range(0, 24) == 0) fresh();
         mode = $urandom_range(0, 2);
         if (mode == 0) begin
            ri = 24'($urandom);
            rq = 24'($urandom);
         end else if (mode == 1) begin
            ri = 24'($urandom_range(0, 40000)) - 24'sd20000;
            rq = 24'($urandom_range(0, 600)) - 24'sd300;
         end else begin
            ri = 24'($urandom_range(0, 2000)) - 24'sd1000;
            rq = 24'($urandom_range(0, 800000)) - 24'sd400000;
         end
         send(ri, rq, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
      end

      repeat (8) tick();
      check("upd_queue_empty", 64'(upd_q.size()), 64'd0);
      check("drop_queue_empty", 64'(drop_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
